// File: rtl/count_binary_pkg.sv
// count_binary_pkg: shared constants and types for the count_binary timer controller.
// Holds the interval-timer s1 register map, control bit positions and the controller state encoding.
`default_nettype none

package count_binary_pkg;

    typedef enum logic [2:0] {
        TMR_STATUS   = 3'd0,
        TMR_CONTROL  = 3'd1,
        TMR_PERIOD_L = 3'd2,
        TMR_PERIOD_H = 3'd3,
        TMR_SNAP_L   = 3'd4,
        TMR_SNAP_H   = 3'd5
    } tmr_addr_e;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    localparam logic [15:0] CTRL_WORD_RUN  = (16'd1 << CTRL_START) | (16'd1 << CTRL_CONT) |
                                             (16'd1 << CTRL_ITO);
    localparam logic [15:0] CTRL_WORD_STOP = 16'd1 << CTRL_STOP;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WR_PL     = 4'd1,
        ST_WR_PH     = 4'd2,
        ST_WR_START  = 4'd3,
        ST_RUN       = 4'd4,
        ST_RD_STATUS = 4'd5,
        ST_RD_WAIT   = 4'd6,
        ST_WR_CLR    = 4'd7,
        ST_WR_STOP   = 4'd8
    } state_e;

endpackage

`default_nettype wire

// File: rtl/count_binary_timer_ctrl.sv
// count_binary_timer_ctrl: Avalon-MM master sequencing the interval timer and counting its interrupts.
// Rev 1.0 - initial release.
`default_nettype none

module count_binary_timer_ctrl
    import count_binary_pkg::*;
#(
    parameter logic [31:0] PERIOD  = 32'h005F_5E0F,
    parameter int          COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [31:0]        period_in,
    input  logic               period_load,
    input  logic               count_clr,
    output logic [2:0]         tmr_address,
    output logic               tmr_chipselect,
    output logic               tmr_write_n,
    output logic [15:0]        tmr_writedata,
    input  logic [15:0]        tmr_readdata,
    input  logic               tmr_irq,
    output logic [COUNT_W-1:0] count,
    output logic               tick,
    output logic               running,
    output logic               busy
);

    state_e             state_q, state_d;
    logic [31:0]        period_q, period_d;
    logic               reload_q, reload_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               rd_unused;

    // Only the TO flag of the status register matters here.
    assign rd_unused = ^tmr_readdata[15:1];
    assign count     = count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            period_q <= PERIOD;
            reload_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            reload_q <= reload_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (enable) state_d = ST_WR_PL;
            ST_WR_PL:     state_d = ST_WR_PH;
            ST_WR_PH:     state_d = ST_WR_START;
            ST_WR_START:  state_d = ST_RUN;
            ST_RUN: begin
                if (!enable)       state_d = ST_WR_STOP;
                else if (reload_q) state_d = ST_WR_PL;
                else if (tmr_irq)  state_d = ST_RD_STATUS;
            end
            ST_RD_STATUS: state_d = ST_RD_WAIT;
            ST_RD_WAIT:   state_d = tmr_readdata[0] ? ST_WR_CLR : ST_RUN;
            ST_WR_CLR:    state_d = ST_RUN;
            ST_WR_STOP:   state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // A reload is consumed by entering the write sequence; in IDLE the next start picks it up anyway.
    always_comb begin
        period_d = period_load ? period_in : period_q;
        reload_d = reload_q;
        if (state_q == ST_IDLE || state_d == ST_WR_PL) begin
            reload_d = 1'b0;
        end else if (period_load) begin
            reload_d = 1'b1;
        end

        count_d = count_q;
        if (count_clr) begin
            count_d = '0;
        end else if (state_q == ST_WR_CLR) begin
            count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_address    = 3'd0;
        tmr_writedata  = 16'd0;
        tick           = 1'b0;
        running        = 1'b0;
        busy           = 1'b0;
        case (state_q)
            ST_WR_PL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = TMR_PERIOD_L;
                tmr_writedata  = period_q[15:0];
                busy           = 1'b1;
            end
            ST_WR_PH: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = TMR_PERIOD_H;
                tmr_writedata  = period_q[31:16];
                busy           = 1'b1;
            end
            ST_WR_START: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = TMR_CONTROL;
                tmr_writedata  = CTRL_WORD_RUN;
                busy           = 1'b1;
            end
            ST_RUN: begin
                running = 1'b1;
            end
            ST_RD_STATUS: begin
                tmr_chipselect = 1'b1;
                tmr_address    = TMR_STATUS;
                running        = 1'b1;
            end
            ST_RD_WAIT: begin
                running = 1'b1;
            end
            ST_WR_CLR: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = TMR_STATUS;
                tick           = 1'b1;
                running        = 1'b1;
            end
            ST_WR_STOP: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = TMR_CONTROL;
                tmr_writedata  = CTRL_WORD_STOP;
                busy           = 1'b1;
            end
            default: begin
                tick = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_count_binary_timer_ctrl.sv
// tb_count_binary_timer_ctrl: scoreboard bench with a behavioural interval-timer slave.
// Rev 1.0 - initial release.
`default_nettype none

module tb_count_binary_timer_ctrl;

    localparam logic [31:0] P = 32'd9;

    logic        clk = 1'b0;
    logic        reset, enable, period_load, count_clr;
    logic [31:0] period_in;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect, tmr_write_n;
    logic [15:0] tmr_writedata, tmr_readdata;
    logic        tmr_irq;
    logic [7:0]  count;
    logic        tick, running, busy;

    always #5 clk = ~clk;

    count_binary_timer_ctrl #(.PERIOD(P), .COUNT_W(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .period_in(period_in),
        .period_load(period_load), .count_clr(count_clr),
        .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
        .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
        .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq),
        .count(count), .tick(tick), .running(running), .busy(busy)
    );

    // Behavioural timer slave: TO every period+1 clocks while running.
    logic [15:0] per_l, per_h;
    logic [31:0] tcnt;
    logic        t_run, t_cont, t_ito, t_to, force_irq;
    wire         t_irq = t_to & t_ito;
    assign tmr_irq = t_irq | force_irq;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            per_l <= P[15:0]; per_h <= P[31:16]; tcnt <= 32'd0;
            t_run <= 1'b0; t_cont <= 1'b0; t_ito <= 1'b0; t_to <= 1'b0;
            tmr_readdata <= 16'd0;
        end else begin
            if (t_run) begin
                if (tcnt == 32'd0) begin
                    t_to <= 1'b1;
                    tcnt <= {per_h, per_l};
                    if (!t_cont) t_run <= 1'b0;
                end else begin
                    tcnt <= tcnt - 32'd1;
                end
            end
            if (tmr_chipselect && !tmr_write_n) begin
                case (tmr_address)
                    3'd0: t_to <= 1'b0;
                    3'd1: begin
                        t_ito  <= tmr_writedata[0];
                        t_cont <= tmr_writedata[1];
                        if (tmr_writedata[2]) t_run <= 1'b1;
                        if (tmr_writedata[3]) t_run <= 1'b0;
                    end
                    3'd2: begin per_l <= tmr_writedata; t_run <= 1'b0; tcnt <= {per_h, tmr_writedata}; end
                    3'd3: begin per_h <= tmr_writedata; t_run <= 1'b0; tcnt <= {tmr_writedata, per_l}; end
                    default: ;
                endcase
            end
            if (tmr_chipselect && tmr_write_n)
                tmr_readdata <= (tmr_address == 3'd0) ? {14'd0, t_run, t_to} : 16'd0;
        end
    end

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
        logic        tk;
        logic [7:0]  cnt;
        int          gap;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0, n_pass = 0;
    int   cyc = 0, last_tick = 0, rise_cyc = 0, ticks = 0, n_reads = 0;
    logic rise_valid = 1'b0, irq_prev = 1'b0;
    logic [7:0] model_cnt = 8'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic note_fail(input string name, input logic [63:0] act);
        n_checks++;
        $display("FAIL %s: got 0x%0h, expected no such event", name, act);
    endtask

    task automatic push_wr(input logic [2:0] a, input logic [15:0] d);
        exp_t e;
        e.addr = a; e.data = d; e.tk = 1'b0; e.cnt = 8'd0; e.gap = 0;
        q.push_back(e);
    endtask

    task automatic push_tick(input logic [7:0] c, input int gap);
        exp_t e;
        e.addr = 3'd0; e.data = 16'd0; e.tk = 1'b1; e.cnt = c; e.gap = gap;
        q.push_back(e);
    endtask

    // Monitor: every bus write pops one expected event.
    always @(negedge clk) begin
        if (!reset) begin
            if (tmr_chipselect && tmr_write_n && tmr_address == 3'd0) n_reads++;
            if (t_irq && !irq_prev && running) begin
                rise_cyc   = cyc;
                rise_valid = 1'b1;
            end
            if (tmr_chipselect && !tmr_write_n) begin
                if (q.size() == 0) begin
                    note_fail("unexpected_write", 64'({tmr_address, tmr_writedata}));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("wr_addr", 64'(tmr_address), 64'(e.addr));
                    check("wr_data", 64'(tmr_writedata), 64'(e.data));
                    check("tick", 64'(tick), 64'(e.tk));
                    check("busy", 64'(busy), 64'(!e.tk));
                    if (e.tk) begin
                        check("count_at_tick", 64'(count), 64'(e.cnt));
                        if (e.gap != 0) check("tick_gap", 64'(cyc - last_tick), 64'(e.gap));
                        if (rise_valid) check("irq_to_tick", 64'(cyc - rise_cyc), 64'd3);
                        rise_valid = 1'b0;
                        last_tick  = cyc;
                        ticks++;
                    end
                end
            end else if (tick) begin
                note_fail("tick_without_clear", 64'(count));
            end
        end
        irq_prev = t_irq;
    end

    task automatic wait_empty(input int budget, input string name);
        for (int i = 0; i < budget && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            note_fail(name, 64'(q.size()));
            q.delete();
        end
    endtask

    task automatic wait_tick(input int budget, input string name);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!tick && i < budget);
        if (!tick) note_fail(name, 64'(i));
    endtask

    task automatic wait_bus(input logic is_wr, input logic [2:0] a, input int budget, input string name);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!(tmr_chipselect && (tmr_write_n == !is_wr) && tmr_address == a) && i < budget);
        if (!(tmr_chipselect && (tmr_write_n == !is_wr) && tmr_address == a)) note_fail(name, 64'(i));
    endtask

    function automatic logic [31:0] out_vec();
        return {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata, count, tick, running, busy};
    endfunction

    localparam logic [31:0] RESET_VEC = {1'b0, 1'b1, 3'd0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0};

    initial begin
        reset = 1'b1; enable = 1'b0; period_load = 1'b0; count_clr = 1'b0;
        period_in = 32'd0; force_irq = 1'b0;
        @(negedge clk);
        check("reset_outputs", 64'(out_vec()), 64'(RESET_VEC));
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Start-up programming and 260 ticks through the count wrap.
        push_wr(3'd2, 16'h0009); push_wr(3'd3, 16'h0000); push_wr(3'd1, 16'h0007);
        for (int k = 0; k < 260; k++) push_tick(8'(k), (k == 0) ? 0 : 10);
        enable = 1'b1;
        wait_empty(3000, "timeout_ticks");
        model_cnt = 8'd4;
        check("tick_total", 64'(ticks), 64'd260);
        check("count_after_wrap", 64'(count), 64'(model_cnt));

        // Reprogram from RUN.
        push_wr(3'd2, 16'h0004); push_wr(3'd3, 16'h0001); push_wr(3'd1, 16'h0007);
        period_in = 32'h0001_0004; period_load = 1'b1;
        @(negedge clk); period_load = 1'b0;
        wait_empty(50, "timeout_reprog");

        // Spurious irq: status read with TO=0.
        repeat (3) @(negedge clk);
        begin
            int rd0;
            rd0 = n_reads;
            force_irq = 1'b1;
            @(negedge clk); force_irq = 1'b0;
            repeat (6) @(negedge clk);
            check("spur_status_read", 64'(n_reads - rd0), 64'd1);
        end
        check("spur_count", 64'(count), 64'(model_cnt));
        check("spur_running", 64'(running), 64'd1);

        // Short period, ticks 5 clocks apart.
        push_wr(3'd2, 16'h0004); push_wr(3'd3, 16'h0000); push_wr(3'd1, 16'h0007);
        push_tick(8'd4, 0); push_tick(8'd5, 5); push_tick(8'd6, 5);
        period_in = 32'd4; period_load = 1'b1;
        @(negedge clk); period_load = 1'b0;
        wait_empty(200, "timeout_short");

        // count_clr coincident with WR_CLR wins over the increment.
        push_tick(8'd7, 5);
        wait_tick(50, "timeout_clr_tick");
        count_clr = 1'b1;
        @(negedge clk); count_clr = 1'b0;
        check("clr_count", 64'(count), 64'd0);
        push_tick(8'd0, 5);
        wait_empty(50, "timeout_after_clr");

        // Enable drop during WR_PH: sequence completes, then stop.
        push_tick(8'd1, 5);
        wait_tick(50, "timeout_sync_tick");
        model_cnt = 8'd2;
        push_wr(3'd2, 16'h0007); push_wr(3'd3, 16'h0000); push_wr(3'd1, 16'h0007);
        push_wr(3'd1, 16'h0008);
        period_in = 32'd7; period_load = 1'b1;
        @(negedge clk); period_load = 1'b0;
        wait_bus(1'b1, 3'd2, 20, "timeout_wr_pl");
        @(posedge clk); #1 enable = 1'b0;
        wait_empty(50, "timeout_stop");
        repeat (30) @(negedge clk);
        check("stopped_running", 64'(running), 64'd0);
        check("stopped_busy", 64'(busy), 64'd0);
        check("stopped_count", 64'(count), 64'(model_cnt));

        // Restart, then reset in the middle of RD_WAIT.
        push_wr(3'd2, 16'h0007); push_wr(3'd3, 16'h0000); push_wr(3'd1, 16'h0007);
        enable = 1'b1;
        wait_bus(1'b0, 3'd0, 30, "timeout_rd_status");
        @(posedge clk); #1 reset = 1'b1;
        #1 check("reset_mid_rd_wait", 64'(out_vec()), 64'(RESET_VEC));
        enable = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("queue_drained", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire
